// File: rtl/intr_pkg.sv
// ---------------------------------------------------------------------------
// intr_pkg -- shared definitions for the interrupt responder.
//
// Holds the responder FSM state encoding, the width of the acknowledge
// down-counter, the reset constants used by every register in the block,
// and a helper that turns the ACK_CYCLES parameter into a counter load value.
// Optional feature macro used by the block: IRQ_SYNC_EN.
// ---------------------------------------------------------------------------
package intr_pkg;

    // Responder FSM states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BND = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_ACK      = 3'd3,
        ST_SERVICE  = 3'd4
    } state_e;

    // Acknowledge down-counter.
    localparam int unsigned ACK_CNT_W   = 4;
    localparam int unsigned ACK_CNT_MAX = (1 << ACK_CNT_W) - 1;
    typedef logic [ACK_CNT_W-1:0] ack_cnt_t;

    // Reset constants.
    localparam state_e      STATE_RST   = ST_IDLE;
    localparam logic [31:0] PC_RST      = '0;
    localparam ack_cnt_t    ACK_CNT_RST = '0;

    // Counter load value for a requested acknowledge length; values outside
    // the counter's 1..15 range are clamped so iack is always at least one
    // cycle long and the counter cannot wrap.
    function automatic ack_cnt_t ack_load(input int unsigned cycles);
        if (cycles == 0) begin
            return ack_cnt_t'(1);
        end else if (cycles > ACK_CNT_MAX) begin
            return ack_cnt_t'(ACK_CNT_MAX);
        end else begin
            return ack_cnt_t'(cycles);
        end
    endfunction

endpackage

// File: rtl/intr_responder_irq_sync.sv
// ---------------------------------------------------------------------------
// irq_sync -- two-flop synchroniser for the asynchronous irq line.
//
// Only present in builds that define IRQ_SYNC_EN; the responder instantiates
// it there and otherwise feeds irq straight into its FSM.
//
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-low reset (both flops clear to 0)
//   d_i  in   raw input
//   q_o  out  synchronised output, two clock edges behind d_i
// ---------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`endif

// File: rtl/intr_responder.sv
// ---------------------------------------------------------------------------
// intr_responder -- takes a level interrupt from the interrupt controller,
// waits for an instruction boundary, redirects fetch to the handler, saves
// the return address, acknowledges the controller, and on return-from-
// interrupt redirects fetch back to the saved address.
//
// Build option: IRQ_SYNC_EN -- when defined, irq passes through a two-flop
// synchroniser (irq_sync) before reaching the FSM, adding two cycles of
// latency. When undefined, irq drives the FSM directly.
//
// Parameters:
//   ACK_CYCLES   cycles iack stays high per accepted interrupt (1..15)
//   IE_RESET     interrupt-enable value after reset
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   irq          in   level interrupt request
//   irq_vec[31:0] in  handler address, captured together with the boundary
//   boundary     in   pipeline is at an instruction boundary
//   pc_next[31:0] in  next fetch address, saved as return address
//   eret         in   return-from-interrupt pulse
//   ie_we        in   interrupt-enable write strobe
//   ie_wd        in   interrupt-enable write data
//   iack         out  acknowledge to the interrupt controller
//   pc_redirect  out  one-cycle fetch redirect strobe
//   pc_target[31:0] out redirect address
//   epc[31:0]    out  saved return address
//   int_active   out  handler running
//   ie           out  current interrupt-enable bit
// ---------------------------------------------------------------------------
module intr_responder
    import intr_pkg::*;
#(
    parameter int unsigned ACK_CYCLES = 1,
    parameter bit          IE_RESET   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq,
    input  logic [31:0] irq_vec,
    input  logic        boundary,
    input  logic [31:0] pc_next,
    input  logic        eret,
    input  logic        ie_we,
    input  logic        ie_wd,
    output logic        iack,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic [31:0] epc,
    output logic        int_active,
    output logic        ie
);

    localparam ack_cnt_t ACK_LOAD = ack_load(ACK_CYCLES);

    // -----------------------------------------------------------------------
    // Interrupt request source for the FSM
    // -----------------------------------------------------------------------
    logic irq_s;

`ifdef IRQ_SYNC_EN
    irq_sync u_irq_sync (
        .clk (clk),
        .rst (rst),
        .d_i (irq),
        .q_o (irq_s)
    );
`else
    assign irq_s = irq;
`endif

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_e      state_q;
    ack_cnt_t    ack_cnt_q;
    logic        iack_q;
    logic        pc_redirect_q;
    logic [31:0] pc_target_q;
    logic [31:0] vec_q;
    logic [31:0] epc_q;
    logic        int_active_q;
    logic        ie_q;

    // The handler address is captured into vec_q when the boundary is taken
    // and only copied onto pc_target on the edge that raises pc_redirect, so
    // pc_target never moves while the redirect strobe is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= STATE_RST;
            ack_cnt_q     <= ACK_CNT_RST;
            iack_q        <= 1'b0;
            pc_redirect_q <= 1'b0;
            pc_target_q   <= PC_RST;
            vec_q         <= PC_RST;
            epc_q         <= PC_RST;
            int_active_q  <= 1'b0;
            ie_q          <= IE_RESET;
        end else begin
            pc_redirect_q <= 1'b0;

            // Software enable write; the REDIRECT clear and the eret set
            // below are later assignments and therefore take priority.
            if (ie_we && (state_q != ST_REDIRECT)) begin
                ie_q <= ie_wd;
            end

            case (state_q)
                ST_IDLE: begin
                    // Acceptance looks at the registered enable, so a write
                    // on this same edge only matters from the next edge on.
                    if (irq_s && ie_q) begin
                        state_q <= ST_WAIT_BND;
                    end
                end

                ST_WAIT_BND: begin
                    // A withdrawn request is checked before the boundary so a
                    // spurious irq never redirects or touches epc.
                    if (!irq_s) begin
                        state_q <= ST_IDLE;
                    end else if (boundary) begin
                        epc_q   <= pc_next;
                        vec_q   <= irq_vec;
                        state_q <= ST_REDIRECT;
                    end
                end

                ST_REDIRECT: begin
                    pc_redirect_q <= 1'b1;
                    pc_target_q   <= vec_q;
                    ie_q          <= 1'b0;
                    ack_cnt_q     <= ACK_LOAD;
                    state_q       <= ST_ACK;
                end

                ST_ACK: begin
                    // One iack cycle per count; the edge that finds the
                    // counter empty drops iack and enters the handler.
                    if (ack_cnt_q != '0) begin
                        iack_q    <= 1'b1;
                        ack_cnt_q <= ack_cnt_q - ack_cnt_t'(1);
                    end else begin
                        iack_q       <= 1'b0;
                        int_active_q <= 1'b1;
                        state_q      <= ST_SERVICE;
                    end
                end

                ST_SERVICE: begin
                    // irq is not looked at here: no nesting.
                    if (eret) begin
                        pc_redirect_q <= 1'b1;
                        pc_target_q   <= epc_q;
                        ie_q          <= 1'b1;
                        int_active_q  <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end

                default: begin
                    iack_q       <= 1'b0;
                    int_active_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign iack        = iack_q;
    assign pc_redirect = pc_redirect_q;
    assign pc_target   = pc_target_q;
    assign epc         = epc_q;
    assign int_active  = int_active_q;
    assign ie          = ie_q;

`ifndef SYNTHESIS
    // Redirect and acknowledge are mutually exclusive.
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst)
        !(pc_redirect_q && iack_q));

    // pc_target only moves on edges that also raise pc_redirect.
    a_target_hold: assert property (@(posedge clk) disable iff (!rst)
        !pc_redirect_q |-> $stable(pc_target_q));
`endif

endmodule

// File: tb/tb_intr_responder.sv
`timescale 1ns/1ps
module tb_intr_responder;

`ifdef IRQ_SYNC_EN
    localparam int unsigned SYNC_LAT = 2;
`else
    localparam int unsigned SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        irq = 1'b0;
    logic        irq3 = 1'b0;
    logic        boundary = 1'b0;
    logic        eret = 1'b0;
    logic        ie_we = 1'b0;
    logic        ie_wd = 1'b0;
    logic [31:0] irq_vec = '0;
    logic [31:0] pc_next = '0;

    logic        iack, pc_redirect, int_active, ie;
    logic [31:0] pc_target, epc;
    logic        iack3, pc_redirect3, int_active3, ie3;
    logic [31:0] pc_target3, epc3;

    intr_responder #(.ACK_CYCLES(1), .IE_RESET(1'b0)) dut (
        .clk(clk), .rst(rst), .irq(irq), .irq_vec(irq_vec), .boundary(boundary),
        .pc_next(pc_next), .eret(eret), .ie_we(ie_we), .ie_wd(ie_wd),
        .iack(iack), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .epc(epc), .int_active(int_active), .ie(ie)
    );

    intr_responder #(.ACK_CYCLES(3), .IE_RESET(1'b0)) dut3 (
        .clk(clk), .rst(rst), .irq(irq3), .irq_vec(irq_vec), .boundary(boundary),
        .pc_next(pc_next), .eret(eret), .ie_we(ie_we), .ie_wd(ie_wd),
        .iack(iack3), .pc_redirect(pc_redirect3), .pc_target(pc_target3),
        .epc(epc3), .int_active(int_active3), .ie(ie3)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pc_next;
        logic [31:0] vec;
        int unsigned bnd_delay;   // ticks before boundary rises (0 = already high)
        int unsigned exp_lat;     // ticks from irq drive to pc_redirect seen
        bit          ie_clash;    // write ie=0 together with eret
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every redirect of the main DUT must match the oldest
    // expected target, and must never coincide with iack.
    always @(negedge clk) begin
        if (rst && pc_redirect) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL redirect_scoreboard: got redirect to 0x%08h, expected none", pc_target);
            end else begin
                chk("redirect_target", pc_target, exp_q.pop_front());
            end
            chk("redirect_iack_excl", {31'b0, iack}, 32'd0);
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned lat = 0;
        int unsigned n_iack = 0;
        int unsigned n_red = 0;
        bit          seen = 1'b0;

        pc_next  = v.pc_next;
        irq_vec  = v.vec;
        boundary = (v.bnd_delay == 0);
        irq      = 1'b1;
        exp_q.push_back(v.vec);
        for (int unsigned i = 1; i <= 30; i++) begin
            tick();
            if (pc_redirect) begin
                lat = i;
                break;
            end
            if (i == v.bnd_delay) boundary = 1'b1;
        end
        chk({tag, "_latency"}, lat, v.exp_lat);
        chk({tag, "_epc"}, epc, v.pc_next);
        chk({tag, "_ie_cleared"}, {31'b0, ie}, 32'd0);

        for (int unsigned i = 0; i < 30; i++) begin
            tick();
            if (int_active) begin
                seen = 1'b1;
                break;
            end
            if (iack) n_iack++;
        end
        chk({tag, "_service_reached"}, {31'b0, seen}, 32'd1);
        chk({tag, "_iack_cycles"}, n_iack, 32'd1);
        chk({tag, "_target_hold"}, pc_target, v.vec);

        // A fresh request during the handler must be ignored.
        irq = 1'b0;
        tick();
        irq = 1'b1;
        n_iack = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            if (iack) n_iack++;
            if (pc_redirect) n_red++;
        end
        irq = 1'b0;
        chk({tag, "_nested_iack"}, n_iack, 32'd0);
        chk({tag, "_nested_redirect"}, n_red, 32'd0);
        chk({tag, "_still_active"}, {31'b0, int_active}, 32'd1);

        // Software enable writes are honoured while in service.
        ie_we = 1'b1; ie_wd = 1'b1;
        tick();
        ie_we = 1'b0;
        chk({tag, "_svc_ie_set"}, {31'b0, ie}, 32'd1);
        ie_we = 1'b1; ie_wd = 1'b0;
        tick();
        ie_we = 1'b0;
        chk({tag, "_svc_ie_clr"}, {31'b0, ie}, 32'd0);

        // Return from interrupt (optionally racing an ie=0 write).
        eret  = 1'b1;
        ie_we = v.ie_clash;
        ie_wd = 1'b0;
        exp_q.push_back(v.pc_next);
        tick();
        eret  = 1'b0;
        ie_we = 1'b0;
        chk({tag, "_eret_redirect"}, {31'b0, pc_redirect}, 32'd1);
        chk({tag, "_eret_target"}, pc_target, v.pc_next);
        chk({tag, "_eret_ie"}, {31'b0, ie}, 32'd1);
        chk({tag, "_eret_inactive"}, {31'b0, int_active}, 32'd0);
        tick();
        chk({tag, "_eret_one_cycle"}, {31'b0, pc_redirect}, 32'd0);

        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk({tag, "_second_eret"}, {31'b0, pc_redirect}, 32'd0);
        chk({tag, "_second_eret_ie"}, {31'b0, ie}, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n_iack;
        int unsigned n_red;
        int unsigned n_act;
        int unsigned lat;
        bit          seen;
        logic [31:0] epc_before;

        tbl[0] = '{32'h0000_0040, 32'h0000_0180, 0, 3 + SYNC_LAT, 1'b0};
        tbl[1] = '{32'h0000_1000, 32'h0000_0200, 1, 3 + SYNC_LAT, 1'b1};
        tbl[2] = '{32'hFFFF_FFFC, 32'h0000_0000, 4, 6,            1'b0};
        tbl[3] = '{32'h0000_0000, 32'hFFFF_FFF0, 7, 9,            1'b1};

        // Reset state
        tick();
        tick();
        chk("rst_iack", {31'b0, iack}, 32'd0);
        chk("rst_redirect", {31'b0, pc_redirect}, 32'd0);
        chk("rst_active", {31'b0, int_active}, 32'd0);
        chk("rst_target", pc_target, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_ie", {31'b0, ie}, 32'd0);
        rst = 1'b1;
        tick();

        ie_we = 1'b1; ie_wd = 1'b1;
        tick();
        ie_we = 1'b0;
        chk("ie_write", {31'b0, ie}, 32'd1);

        for (int unsigned t = 0; t < 4; t++) begin
            run_vec(tbl[t], $sformatf("vec%0d", t));
        end

        // Withdrawn request while the boundary is held off.
        epc_before = epc;
        pc_next  = 32'hDEAD_0000;
        irq_vec  = 32'h0000_0300;
        boundary = 1'b0;
        irq      = 1'b1;
        n_iack = 0; n_red = 0;
        for (int unsigned i = 1; i <= 8; i++) begin
            tick();
            if (iack) n_iack++;
            if (pc_redirect) n_red++;
            if (i == 3) irq = 1'b0;
            if (i == 5) boundary = 1'b1;
        end
        chk("spur_iack", n_iack, 32'd0);
        chk("spur_redirect", n_red, 32'd0);
        chk("spur_epc", epc, epc_before);
        chk("spur_active", {31'b0, int_active}, 32'd0);
        run_vec(tbl[0], "after_spur");

        // Disabled interrupt, then enabled by software.
        ie_we = 1'b1; ie_wd = 1'b0;
        tick();
        ie_we = 1'b0;
        chk("ie_off", {31'b0, ie}, 32'd0);
        pc_next = 32'h0000_0040; irq_vec = 32'h0000_0180;
        boundary = 1'b1; irq = 1'b1;
        n_iack = 0; n_red = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            tick();
            if (iack) n_iack++;
            if (pc_redirect) n_red++;
        end
        chk("ie_off_iack", n_iack, 32'd0);
        chk("ie_off_redirect", n_red, 32'd0);
        ie_we = 1'b1; ie_wd = 1'b1;
        exp_q.push_back(32'h0000_0180);
        lat = 0;
        for (int unsigned i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) begin
                ie_we = 1'b0;
                chk("ie_on_read", {31'b0, ie}, 32'd1);
            end
            if (pc_redirect) begin
                lat = i;
                break;
            end
        end
        chk("ie_on_latency", lat, 32'd4);
        seen = 1'b0;
        for (int unsigned i = 0; i < 30; i++) begin
            tick();
            if (int_active) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ie_on_service", {31'b0, seen}, 32'd1);
        irq = 1'b0;
        repeat (3) tick();
        eret = 1'b1;
        exp_q.push_back(32'h0000_0040);
        tick();
        eret = 1'b0;
        chk("ie_on_eret_target", pc_target, 32'h0000_0040);
        tick();

        // ACK_CYCLES=3 instance: full run, then reset during second iack.
        irq3 = 1'b1;
        n_iack = 0; seen = 1'b0;
        for (int unsigned i = 0; i < 40; i++) begin
            tick();
            if (int_active3) begin
                seen = 1'b1;
                break;
            end
            if (iack3) n_iack++;
        end
        chk("ack3_service", {31'b0, seen}, 32'd1);
        chk("ack3_iack_cycles", n_iack, 32'd3);
        chk("ack3_target", pc_target3, 32'h0000_0180);
        irq3 = 1'b0;
        repeat (3) tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("ack3_eret_redirect", {31'b0, pc_redirect3}, 32'd1);
        chk("ack3_eret_target", pc_target3, 32'h0000_0040);
        tick();

        irq3 = 1'b1;
        seen = 1'b0;
        for (int unsigned i = 0; i < 30; i++) begin
            tick();
            if (iack3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst3_first_iack", {31'b0, seen}, 32'd1);
        tick();
        chk("rst3_second_iack", {31'b0, iack3}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst3_iack", {31'b0, iack3}, 32'd0);
        chk("rst3_redirect", {31'b0, pc_redirect3}, 32'd0);
        chk("rst3_active", {31'b0, int_active3}, 32'd0);
        chk("rst3_target", pc_target3, 32'd0);
        chk("rst3_epc", epc3, 32'd0);
        chk("rst3_ie", {31'b0, ie3}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        n_iack = 0; n_red = 0; n_act = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            if (iack3) n_iack++;
            if (pc_redirect3) n_red++;
            if (int_active3) n_act++;
        end
        chk("rst3_post_iack", n_iack, 32'd0);
        chk("rst3_post_redirect", n_red, 32'd0);
        chk("rst3_post_active", n_act, 32'd0);
        irq3 = 1'b0;

        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
